// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// FSM states and lane-mask helpers used by the responder and its bank.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte lanes covered by an access of the given size, before offset shift.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage built from four byte-lane arrays; synchronous
// per-lane write, combinational read, both at the same word index.
module dmem_bank #(
    parameter int WORDS = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [3:0]       i_we,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [7:0] r_mem [4][WORDS];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                r_mem[l][i_idx] <= i_wdata[8*l +: 8];
            end
        end
    end

    assign o_rdata = {r_mem[3][i_idx], r_mem[2][i_idx], r_mem[1][i_idx], r_mem[0][i_idx]};

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, waits WAIT_CYCLES,
// performs a little-endian byte/half/word access and emits a one-cycle response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORDS  = DEPTH_BYTES / 4;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_access;
    logic [31:0]       w_cur_addr;
    logic [1:0]        w_cur_size;
    logic              w_cur_wen;
    logic [31:0]       w_cur_wdata;
    logic [1:0]        w_off;
    logic [3:0]        w_lanes;
    logic              w_err;
    logic [WIDX_W-1:0] w_widx;
    logic [3:0]        w_bank_we;
    logic [31:0]       w_bank_wdata;
    logic [31:0]       w_bank_rdata;
    logic [31:0]       w_rsp_rdata;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_access  = (r_state == ST_WAIT && r_cnt == 4'd0) || (NO_WAIT && w_accept);

    // With no wait states the access happens on the accept edge itself, so the
    // live request is used while idle; otherwise only the captured copy is.
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_size  = (r_state == ST_IDLE) ? req_size  : r_size;
    assign w_cur_wen   = (r_state == ST_IDLE) ? req_wen   : r_wen;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_off   = w_cur_addr[1:0];
    assign w_lanes = size_lanes(w_cur_size);
    assign w_widx  = w_cur_addr[WIDX_W+1:2];
    assign w_err   = (w_cur_size == SZ_RSVD)
                  || (w_cur_size == SZ_HALF && w_cur_addr[0])
                  || (w_cur_size == SZ_WORD && w_cur_addr[1:0] != 2'b00)
                  || (w_cur_addr >= 32'(DEPTH_BYTES));

    // Lane steering: shift right-aligned write data and lane mask up to the
    // byte offset, and shift read data back down before masking to size.
    assign w_bank_we    = (w_access && w_cur_wen && !w_err) ? (w_lanes << w_off) : 4'b0000;
    assign w_bank_wdata = w_cur_wdata << {w_off, 3'b000};
    assign w_rsp_rdata  = (w_cur_wen || w_err) ? 32'd0
                        : ((w_bank_rdata >> {w_off, 3'b000}) & lanes_to_bits(w_lanes));

    dmem_bank #(
        .WORDS (WORDS),
        .IDX_W (WIDX_W)
    ) u_bank (
        .clk     (clk),
        .i_idx   (w_widx),
        .i_we    (w_bank_we),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_size      <= 2'd0;
            r_wen       <= 1'b0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_wen   <= req_wen;
                        r_wdata <= req_wdata;
                        if (NO_WAIT) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= w_rsp_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= w_rsp_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with none, sharing the request payload but with separate valids.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;

    logic        req_valid2 = 1'b0, req_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_rdata2;
    logic        req_valid0 = 1'b0, req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int n_acc2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (req_valid2 && req_ready2) n_acc2 <= n_acc2 + 1;

    dmem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr), .req_size(req_size), .req_wen(req_wen), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
    );

    dmem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_size(req_size), .req_wen(req_wen), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation,
    // including the cycle it was due in.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid2) begin
                if (q2.size() == 0) begin
                    check("w2_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    check("w2_rdata", rsp_rdata2, e.rdata);
                    check("w2_err", 32'(rsp_err2), 32'(e.err));
                    check("w2_latency_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (rsp_valid0) begin
                if (q0.size() == 0) begin
                    check("w0_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("w0_rdata", rsp_rdata0, e.rdata);
                    check("w0_err", 32'(rsp_err0), 32'(e.err));
                    check("w0_latency_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Issue one request to instance sel (0: two wait states, 1: none) and
    // queue its expected response; payload is scrambled right after accept.
    task automatic do_req(input int sel, input logic wen, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit keep, input bit want_rsp, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_addr = addr; req_size = sz; req_wen = wen; req_wdata = wd;
        if (sel == 0) req_valid2 = 1'b1; else req_valid0 = 1'b1;
        n = 0;
        acc = -1;
        while (!((sel == 0) ? req_ready2 : req_ready0)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                req_valid2 = 1'b0; req_valid0 = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (want_rsp) begin
            e.rdata = exp_rd; e.err = exp_err; e.due = cyc + ((sel == 0) ? 2 : 0);
            if (sel == 0) q2.push_back(e); else q0.push_back(e);
        end
        if (!keep) begin
            req_valid2 = 1'b0; req_valid0 = 1'b0;
        end
        req_addr = 32'h0000_0002; req_size = SZ_RSVD; req_wen = ~wen; req_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        int acc;
        int a3[3];
        int n;
        int acc_base;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready2), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid2), 32'd0);
        check("rst_rsp_err", 32'(rsp_err2), 32'd0);
        check("rst_rsp_rdata", rsp_rdata2, 32'd0);
        rst = 1'b0;

        do_req(0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_BYTE, 32'h11, 32'h0, 32'h0000_00BE, 1'b0, 0, 1, acc);
        do_req(0, 1'b1, SZ_HALF, 32'h12, 32'h0000_1234, 32'h0, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 0, 1, acc);
        do_req(0, 1'b1, SZ_WORD, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1, acc);

        // Error cases, then readback to prove nothing was written.
        do_req(0, 1'b0, SZ_WORD, 32'h02, 32'h0, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b0, SZ_HALF, 32'h13, 32'h0, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b0, SZ_RSVD, 32'h00, 32'h0, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h400, 32'h0, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b1, SZ_HALF, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b1, SZ_BYTE, 32'h400, 32'h0000_00FF, 32'h0, 1'b1, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0, 0, 1, acc);

        do_req(0, 1'b0, SZ_BYTE, 32'h13, 32'h0, 32'h0000_0012, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_HALF, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 0, 1, acc);
        do_req(0, 1'b1, SZ_BYTE, 32'h13, 32'hFFFF_FF56, 32'h0, 1'b0, 0, 1, acc);
        do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'h5634_BEEF, 1'b0, 0, 1, acc);

        // Valid held high across three requests.
        acc_base = n_acc2;
        do_req(0, 1'b0, SZ_WORD, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1, a3[0]);
        do_req(0, 1'b0, SZ_BYTE, 32'h01, 32'h0, 32'h0000_00F0, 1'b0, 1, 1, a3[1]);
        do_req(0, 1'b0, SZ_HALF, 32'h12, 32'h0, 32'h0000_5634, 1'b0, 0, 1, a3[2]);
        repeat (6) @(negedge clk);
        check("hold_accept_count", 32'(n_acc2 - acc_base), 32'd3);
        check("hold_spacing_1", 32'(a3[1] - a3[0]), 32'd4);
        check("hold_spacing_2", 32'(a3[2] - a3[1]), 32'd4);

        // Reset during the wait phase of a write aborts it.
        do_req(0, 1'b1, SZ_WORD, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 0, 1, acc);
        do_req(0, 1'b1, SZ_WORD, 32'h20, 32'hAAAA_5555, 32'h0, 1'b0, 0, 0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready2), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid2), 32'd0);
        do_req(0, 1'b0, SZ_WORD, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 0, 1, acc);

        // Zero-wait instance: response in the cycle after accept.
        do_req(1, 1'b1, SZ_WORD, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 1, acc);
        do_req(1, 1'b0, SZ_WORD, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 1, acc);
        do_req(1, 1'b0, SZ_HALF, 32'h11, 32'h0, 32'h0, 1'b1, 0, 1, acc);

        n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q2.size() != 0 || q0.size() != 0)
            check("drain_pending_rsp", 32'(q2.size() + q0.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
